// File: rtl/exu_pkg.sv
// Shared definitions for the execution-unit operand-fetch slice: widths and
// the op record that travels alongside the operands from decode to the ALU.
package exu_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);
    localparam int OPW  = 8;

    // Fields that ride through the stage untouched
    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [AW-1:0]   rd;
        logic            rd_en;
        logic [XLEN-1:0] imm;
    } exu_op_t;

endpackage

// File: rtl/exu_operand_fetch_if.sv
// Bus bundle around the operand-fetch stage: decode input, register file
// read ports, writeback bus and the ALU output.
//
// Handshakes (in_* and out_*): a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holding valid=1 keeps its payload
// stable until the transfer; ready may depend combinationally on the inputs.
// wb_* has no ready: a writeback is taken in every cycle wb_valid is 1.
interface exu_operand_fetch_if;
    import exu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  in_op;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic            in_use1;
    logic            in_use2;
    logic [AW-1:0]   in_rd;
    logic            in_rd_en;
    logic [XLEN-1:0] in_imm;

    logic [AW-1:0]   rf_raddr1;
    logic [AW-1:0]   rf_raddr2;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;

    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    logic            out_valid;
    logic            out_ready;
    logic [OPW-1:0]  out_op;
    logic [XLEN-1:0] out_imm;
    logic [AW-1:0]   out_rd;
    logic            out_rd_en;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;

    // Decode / register file / writeback / ALU side
    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_rd_en, in_imm,
        input  in_ready,
        input  rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2,
        output wb_valid, wb_addr, wb_data,
        input  out_valid, out_op, out_imm, out_rd, out_rd_en, out_a, out_b,
        output out_ready
    );

    // Operand-fetch stage side
    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_rd_en, in_imm,
        output in_ready,
        output rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2,
        input  wb_valid, wb_addr, wb_data,
        output out_valid, out_op, out_imm, out_rd, out_rd_en, out_a, out_b,
        input  out_ready
    );

endinterface

// File: rtl/exu_scoreboard.sv
// Per-register pending-write tracker. A register is busy from the cycle its
// writer is accepted until its writeback; r0 is never busy.
module exu_scoreboard
    import exu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    input  logic [AW-1:0]   dst_addr,
    output logic            busy1,
    output logic            busy2,
    output logic            busy_dst,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next busy vector: clear first so a same-cycle new writer wins
    always_comb begin
        busy_d = busy_q;
        if (clr_en && clr_addr != '0) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && set_addr != '0) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1    = busy_q[rd_addr1];
    assign busy2    = busy_q[rd_addr2];
    assign busy_dst = busy_q[dst_addr];
    assign busy_vec = busy_q;

endmodule

// File: rtl/exu_operand_fetch.sv
// Operand-fetch stage: decode op accepted into s1 while the register file is
// read, operands resolved in s1 (zero / bypass / register data), then handed
// to the ALU from the out registers. Accept at N gives out_valid at N+2.
module exu_operand_fetch
    import exu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    exu_operand_fetch_if.slave bus,
    output logic [NREG-1:0]   dbg_busy
);

    // s1 stage state
    logic            s1_valid_q, s1_valid_d;
    exu_op_t         s1_op_q,    s1_op_d;
    logic            s1_use1_q,  s1_use1_d;
    logic            s1_use2_q,  s1_use2_d;
    logic            s1_byp1_q,  s1_byp1_d;
    logic            s1_byp2_q,  s1_byp2_d;
    logic [XLEN-1:0] s1_bdat1_q, s1_bdat1_d;
    logic [XLEN-1:0] s1_bdat2_q, s1_bdat2_d;

    // out stage state
    logic            out_valid_q, out_valid_d;
    exu_op_t         out_op_q,    out_op_d;
    logic [XLEN-1:0] out_a_q,     out_a_d;
    logic [XLEN-1:0] out_b_q,     out_b_d;

    logic            busy1, busy2, busy_dst;
    logic            wb_hit1, wb_hit2, wb_hitd;
    logic            haz1, haz2, hazd;
    logic            out_free;
    logic            in_ready;
    logic            accept;
    logic [XLEN-1:0] op_a, op_b;

    exu_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (accept && bus.in_rd_en),
        .set_addr (bus.in_rd),
        .clr_en   (bus.wb_valid),
        .clr_addr (bus.wb_addr),
        .rd_addr1 (bus.in_rs1),
        .rd_addr2 (bus.in_rs2),
        .dst_addr (bus.in_rd),
        .busy1    (busy1),
        .busy2    (busy2),
        .busy_dst (busy_dst),
        .busy_vec (dbg_busy)
    );

    // Read addresses follow the decode fields every cycle
    assign bus.rf_raddr1 = bus.in_use1 ? bus.in_rs1 : '0;
    assign bus.rf_raddr2 = bus.in_use2 ? bus.in_rs2 : '0;

    // Hazards against pending writers, forgiven when the writeback lands now
    always_comb begin
        wb_hit1  = bus.wb_valid && (bus.wb_addr == bus.in_rs1);
        wb_hit2  = bus.wb_valid && (bus.wb_addr == bus.in_rs2);
        wb_hitd  = bus.wb_valid && (bus.wb_addr == bus.in_rd);
        haz1     = bus.in_use1  && (bus.in_rs1 != '0) && busy1    && !wb_hit1;
        haz2     = bus.in_use2  && (bus.in_rs2 != '0) && busy2    && !wb_hit2;
        hazd     = bus.in_rd_en && (bus.in_rd  != '0) && busy_dst && !wb_hitd;
        out_free = !out_valid_q || bus.out_ready;
        in_ready = !haz1 && !haz2 && !hazd && (!s1_valid_q || out_free);
        accept   = bus.in_valid && in_ready;
    end

    assign bus.in_ready = in_ready;

    // Operand resolution for the op sitting in s1
    always_comb begin
        op_a = !s1_use1_q ? '0 : (s1_byp1_q ? s1_bdat1_q : bus.rf_rdata1);
        op_b = !s1_use2_q ? '0 : (s1_byp2_q ? s1_bdat2_q : bus.rf_rdata2);
    end

    // s1 next state: load on accept, or freeze resolved operands when blocked
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_use1_d  = s1_use1_q;
        s1_use2_d  = s1_use2_q;
        s1_byp1_d  = s1_byp1_q;
        s1_byp2_d  = s1_byp2_q;
        s1_bdat1_d = s1_bdat1_q;
        s1_bdat2_d = s1_bdat2_q;
        if (s1_valid_q && !out_free) begin
            // Register read data is only valid this cycle; keep it as bypass data
            s1_byp1_d  = 1'b1;
            s1_byp2_d  = 1'b1;
            s1_bdat1_d = op_a;
            s1_bdat2_d = op_b;
        end else begin
            s1_valid_d = accept;
            if (accept) begin
                s1_op_d.op    = bus.in_op;
                s1_op_d.rd    = bus.in_rd;
                s1_op_d.rd_en = bus.in_rd_en;
                s1_op_d.imm   = bus.in_imm;
                s1_use1_d     = bus.in_use1;
                s1_use2_d     = bus.in_use2;
                s1_byp1_d     = bus.in_use1 && (bus.in_rs1 != '0) && wb_hit1;
                s1_byp2_d     = bus.in_use2 && (bus.in_rs2 != '0) && wb_hit2;
                s1_bdat1_d    = bus.wb_data;
                s1_bdat2_d    = bus.wb_data;
            end
        end
    end

    // out next state: refill from s1 when free, otherwise drop on consume
    always_comb begin
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        if (s1_valid_q && out_free) begin
            out_valid_d = 1'b1;
            out_op_d    = s1_op_q;
            out_a_d     = op_a;
            out_b_d     = op_b;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // s1 registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_use1_q  <= 1'b0;
            s1_use2_q  <= 1'b0;
            s1_byp1_q  <= 1'b0;
            s1_byp2_q  <= 1'b0;
            s1_bdat1_q <= '0;
            s1_bdat2_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_use1_q  <= s1_use1_d;
            s1_use2_q  <= s1_use2_d;
            s1_byp1_q  <= s1_byp1_d;
            s1_byp2_q  <= s1_byp2_d;
            s1_bdat1_q <= s1_bdat1_d;
            s1_bdat2_q <= s1_bdat2_d;
        end
    end

    // out registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_op_q.op;
    assign bus.out_imm   = out_op_q.imm;
    assign bus.out_rd    = out_op_q.rd;
    assign bus.out_rd_en = out_op_q.rd_en;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;

endmodule
